inst_fetch: RTL

Instruction fetch front-end that drives the read port of `inst_mem` and hands fetched instructions to decode. It owns the program counter, issues one-cycle-latency reads, and tracks the instruction held in the memory's output register. It delivers each instruction with its PC over a valid/ready interface, and accepts PC redirects from the branch unit.

---
 rtl/inst_fetch.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues one-cycle-latency reads to inst_mem and hands
// words to decode over valid/ready. Define FETCH_WRAP_EN to wrap the PC at the end of memory.
module inst_fetch #(
   parameter int INST_WIDTH = 32,
   parameter int MEM_SIZE   = 16,
   parameter int RESET_PC   = 0,
   localparam int AW        = $clog2(MEM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  redirect_valid,
   input  logic [AW-1:0]         redirect_pc,
   output logic                  mem_rd_en,
   output logic [AW-1:0]         mem_rd_addr,
   input  logic [INST_WIDTH-1:0] mem_instruction,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INST_WIDTH-1:0] out_instr,
   output logic [AW-1:0]         out_pc
);

   localparam logic [AW-1:0] LAST_PC  = AW'(MEM_SIZE - 1);
   localparam logic [AW-1:0] START_PC = AW'(RESET_PC);

   logic [AW-1:0] pc;
   logic [AW-1:0] mem_pc;
   logic          mem_vld;
   logic          halted;
   logic          capture;
   logic          issue;

   // The memory output register is only read when it is moving into the output register,
   // and a new read is only allowed once the old word has left (or leaves this cycle).
   always_comb begin
      capture = mem_vld & ~redirect_valid & (~out_valid | out_ready);
      issue   = en & ~halted & ~redirect_valid & (~mem_vld | capture);
   end

   assign mem_rd_en   = rst_n & issue;
   assign mem_rd_addr = rst_n ? pc : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= START_PC;
         mem_vld   <= 1'b0;
         mem_pc    <= '0;
         halted    <= 1'b0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else if (redirect_valid) begin
         pc        <= redirect_pc;
         mem_vld   <= 1'b0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         if (capture) begin
            out_instr <= mem_instruction;
            out_pc    <= mem_pc;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (issue) begin
            mem_vld <= 1'b1;
            mem_pc  <= pc;
            // Wrap is an explicit compare so non-power-of-two depths behave correctly.
            if (pc == LAST_PC) begin
`ifdef FETCH_WRAP_EN
               pc <= '0;
`else
               halted <= 1'b1;
`endif
            end else begin
               pc <= pc + AW'(1);
            end
         end else if (capture) begin
            mem_vld <= 1'b0;
         end
      end
   end

endmodule
